// File: rtl/req_pkg.sv
// req_pkg: shared opcodes, instruction record and width helpers for the dispatch queue
package req_pkg;
  localparam logic [1:0] OP_AES = 2'b00;
  localparam logic [1:0] OP_SHA = 2'b10;
  localparam int DEF_ADDRW = 24;
  localparam int DEF_OPCODEW = 2;
  typedef struct packed {
    logic [DEF_OPCODEW-1:0] opcode;
    logic [DEF_ADDRW-1:0]   key;
    logic [DEF_ADDRW-1:0]   text;
    logic [DEF_ADDRW-1:0]   dest;
  } req_t;
  function automatic int iw(input int addrw, input int opcodew);
    return 3 * addrw + opcodew;
  endfunction
  function automatic req_t pack_req(input logic [1:0] op, input logic [23:0] k, input logic [23:0] t, input logic [23:0] d);
    return '{opcode: op, key: k, text: t, dest: d};
  endfunction
endpackage

// File: rtl/req_fifo.sv
// req_fifo: first-word-fall-through FIFO with push/pop/flush and level (ports: clk, rst, push_i, pop_i, flush_i, data_i, data_o, valid_o, full_o, level_o)
module req_fifo import req_pkg::*; #(
  parameter int W = 74,
  parameter int QDEPTH = 16,
  localparam int LW = $clog2(QDEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic          valid_o,
  output logic          full_o,
  output logic [LW-1:0] level_o
);
  localparam int AW = LW - 1;
  logic [W-1:0] mem_q [QDEPTH];
  logic [LW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic full, empty, do_push, do_pop;
  always_comb begin
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    empty = wr_q == rd_q;
    do_push = push_i & ~full & ~flush_i;
    do_pop = pop_i & ~empty & ~flush_i;
    wr_d = flush_i ? '0 : wr_q + LW'(do_push);
    rd_d = flush_i ? '0 : rd_q + LW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
  assign data_o = mem_q[rd_q[AW-1:0]];
  assign valid_o = ~empty;
  assign full_o = full;
  assign level_o = wr_q - rd_q;
endmodule

// File: rtl/req_dispatch_queue.sv
// req_dispatch_queue: routes crypto requests by opcode into NCH per-engine FIFOs (ports: request in, per-channel head/valid/ready/flush/level, err_route)
module req_dispatch_queue import req_pkg::*; #(
  parameter int ADDRW = 24,
  parameter int OPCODEW = 2,
  parameter int NCH = 2,
  parameter int QDEPTH = 16,
  parameter int CHSEL_LSB = 1,
  localparam int IW = iw(ADDRW, OPCODEW),
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1,
  localparam int LW = $clog2(QDEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [OPCODEW-1:0] opcode,
  input  logic [ADDRW-1:0]  key_addr,
  input  logic [ADDRW-1:0]  text_addr,
  input  logic [ADDRW-1:0]  dest_addr,
  output logic [NCH-1:0]    ready_in_ch,
  output logic [NCH*IW-1:0] instr_out,
  output logic [NCH-1:0]    valid_out,
  input  logic [NCH-1:0]    ready_out,
  input  logic [NCH-1:0]    flush,
  output logic [NCH*LW-1:0] level,
  output logic              err_route
);
  localparam logic [CHW:0] NCH_W = (CHW + 1)'(NCH);
  logic [CHW-1:0] ch;
  logic bad, err_route_q, err_route_d;
  logic [NCH-1:0] sel, full;
  assign ch = opcode[CHSEL_LSB+:CHW];
  assign bad = {1'b0, ch} >= NCH_W;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign sel[i] = ~bad & (ch == CHW'(i));
    req_fifo #(.W(IW), .QDEPTH(QDEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push_i(valid_in & sel[i]),
      .pop_i(ready_out[i]),
      .flush_i(flush[i]),
      .data_i({opcode, key_addr, text_addr, dest_addr}),
      .data_o(instr_out[i*IW+:IW]),
      .valid_o(valid_out[i]),
      .full_o(full[i]),
      .level_o(level[i*LW+:LW])
    );
  end
  assign ready_in_ch = ~full;
  assign ready_in = bad | |(sel & ready_in_ch & ~flush);
  assign err_route_d = valid_in & bad;
  always_ff @(posedge clk) begin
    if (rst) err_route_q <= 1'b0;
    else err_route_q <= err_route_d;
  end
  assign err_route = err_route_q;
endmodule

// File: tb/tb_req_dispatch_queue.sv
// tb_req_dispatch_queue: directed table and sequence checks of the dispatch queue
module tb_req_dispatch_queue;
  import req_pkg::*;
  localparam int IW = 74;
  localparam int LW = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic valid_in, ready_in, err_route;
  logic [1:0] opcode, ready_in_ch, valid_out, ready_out, flush;
  logic [23:0] key_addr, text_addr, dest_addr;
  logic [2*IW-1:0] instr_out;
  logic [2*LW-1:0] level;
  logic v3, r3, e3;
  logic [1:0] op3;
  logic [2:0] rich3, vo3, ro3, fl3;
  logic [3*IW-1:0] io3;
  logic [3*LW-1:0] lvl3;
  int total = 0;
  int passed = 0;

  req_dispatch_queue dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in), .opcode(opcode),
    .key_addr(key_addr), .text_addr(text_addr), .dest_addr(dest_addr),
    .ready_in_ch(ready_in_ch), .instr_out(instr_out), .valid_out(valid_out),
    .ready_out(ready_out), .flush(flush), .level(level), .err_route(err_route)
  );

  req_dispatch_queue #(.NCH(3), .CHSEL_LSB(0)) dut3 (
    .clk(clk), .rst(rst), .valid_in(v3), .ready_in(r3), .opcode(op3),
    .key_addr(key_addr), .text_addr(text_addr), .dest_addr(dest_addr),
    .ready_in_ch(rich3), .instr_out(io3), .valid_out(vo3),
    .ready_out(ro3), .flush(fl3), .level(lvl3), .err_route(e3)
  );

  typedef struct {
    logic v; logic [1:0] op; logic [23:0] k; logic [1:0] ro;
    logic exp_rdy; logic [1:0] exp_vo; logic [4:0] exp_l0, exp_l1; logic [23:0] exp_k0, exp_k1;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [23:0] k);
    valid_in = v;
    opcode = op;
    key_addr = k;
    text_addr = k + 24'h10;
    dest_addr = k + 24'h20;
  endtask

  function automatic logic [IW-1:0] exp_req(input logic [1:0] op, input logic [23:0] k);
    return pack_req(op, k, k + 24'h10, k + 24'h20);
  endfunction

  initial begin
    vecs = '{
      '{1'b1, OP_AES, 24'h10, 2'b00, 1'b1, 2'b01, 5'd1, 5'd0, 24'h10, 24'h0},
      '{1'b1, OP_SHA, 24'h11, 2'b00, 1'b1, 2'b11, 5'd1, 5'd1, 24'h10, 24'h11},
      '{1'b0, OP_AES, 24'h0,  2'b01, 1'b1, 2'b10, 5'd0, 5'd1, 24'h0,  24'h11},
      '{1'b0, OP_AES, 24'h0,  2'b10, 1'b1, 2'b00, 5'd0, 5'd0, 24'h0,  24'h0},
      '{1'b1, OP_SHA, 24'h12, 2'b00, 1'b1, 2'b10, 5'd0, 5'd1, 24'h0,  24'h12},
      '{1'b1, OP_AES, 24'h13, 2'b10, 1'b1, 2'b01, 5'd1, 5'd0, 24'h13, 24'h0},
      '{1'b0, OP_AES, 24'h0,  2'b01, 1'b1, 2'b00, 5'd0, 5'd0, 24'h0,  24'h0}
    };
    drive(1'b1, OP_AES, 24'h10);
    ready_out = 2'b00;
    flush = 2'b00;
    v3 = 1'b1;
    op3 = 2'b00;
    ro3 = 3'b000;
    fl3 = 3'b000;
    for (int r = 0; r < 2; r++) begin
      tick;
      chk("rst_ready_in_ch", ready_in_ch, 2'b11);
      chk("rst_valid_out", valid_out, 2'b00);
      chk("rst_level", level, 10'd0);
      chk("rst_level3", lvl3, 15'd0);
    end
    rst = 1'b0;
    drive(1'b0, OP_AES, 24'h0);
    v3 = 1'b0;
    tick;
    chk("post_rst_level", level, 10'd0);
    chk("post_rst_valid_out", valid_out, 2'b00);
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].k);
      ready_out = vecs[i].ro;
      #1;
      chk($sformatf("vec%0d_ready_in", i), ready_in, vecs[i].exp_rdy);
      tick;
      chk($sformatf("vec%0d_valid_out", i), valid_out, vecs[i].exp_vo);
      chk($sformatf("vec%0d_level0", i), level[0+:LW], vecs[i].exp_l0);
      chk($sformatf("vec%0d_level1", i), level[LW+:LW], vecs[i].exp_l1);
      if (vecs[i].exp_vo[0]) chk($sformatf("vec%0d_instr0", i), instr_out[0+:IW], exp_req(OP_AES, vecs[i].exp_k0));
      if (vecs[i].exp_vo[1]) chk($sformatf("vec%0d_instr1", i), instr_out[IW+:IW], exp_req(OP_SHA, vecs[i].exp_k1));
    end
    ready_out = 2'b00;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, OP_AES, 24'h100 + 24'(i));
      #1;
      chk($sformatf("full_ready_in%0d", i), ready_in, i < 16);
      tick;
    end
    chk("full_level0", level[0+:LW], 5'd16);
    chk("full_ready_in_ch", ready_in_ch, 2'b10);
    drive(1'b1, OP_SHA, 24'h200);
    #1;
    chk("full_ch1_ready_in", ready_in, 1'b1);
    tick;
    chk("full_ch1_level1", level[LW+:LW], 5'd1);
    ready_out = 2'b11;
    drive(1'b1, OP_AES, 24'hBAD);
    #1;
    chk("full_pop_no_push", ready_in, 1'b0);
    chk("drain_head0", instr_out[0+:IW], exp_req(OP_AES, 24'h100));
    tick;
    drive(1'b0, OP_AES, 24'h0);
    chk("drain_level0_15", level[0+:LW], 5'd15);
    for (int j = 1; j < 16; j++) begin
      chk($sformatf("drain_valid%0d", j), valid_out[0], 1'b1);
      chk($sformatf("drain_head%0d", j), instr_out[0+:IW], exp_req(OP_AES, 24'h100 + 24'(j)));
      tick;
    end
    chk("drain_level", level, 10'd0);
    chk("drain_valid_out", valid_out, 2'b00);
    ready_out = 2'b00;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, OP_AES, 24'h300 + 24'(i));
      tick;
    end
    chk("sim_level0_init", level[0+:LW], 5'd5);
    ready_out = 2'b01;
    for (int c = 0; c < 40; c++) begin
      drive(1'b1, OP_AES, 24'h305 + 24'(c));
      #1;
      chk($sformatf("sim_head%0d", c), instr_out[0+:IW], exp_req(OP_AES, 24'h300 + 24'(c)));
      tick;
      chk($sformatf("sim_level%0d", c), level[0+:LW], 5'd5);
    end
    drive(1'b0, OP_AES, 24'h0);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("sim_tail%0d", c), instr_out[0+:IW], exp_req(OP_AES, 24'h328 + 24'(c)));
      tick;
    end
    chk("sim_level_end", level[0+:LW], 5'd0);
    ready_out = 2'b00;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, OP_AES, 24'h400 + 24'(i));
      tick;
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_SHA, 24'h500 + 24'(i));
      tick;
    end
    chk("flush_pre_l0", level[0+:LW], 5'd7);
    chk("flush_pre_l1", level[LW+:LW], 5'd3);
    flush = 2'b01;
    drive(1'b1, OP_AES, 24'hBAD);
    #1;
    chk("flush_ready_in", ready_in, 1'b0);
    tick;
    flush = 2'b00;
    drive(1'b0, OP_AES, 24'h0);
    chk("flush_l0", level[0+:LW], 5'd0);
    chk("flush_l1", level[LW+:LW], 5'd3);
    chk("flush_valid_out", valid_out, 2'b10);
    chk("flush_head1", instr_out[IW+:IW], exp_req(OP_SHA, 24'h500));
    flush = 2'b10;
    ready_out = 2'b10;
    tick;
    flush = 2'b00;
    ready_out = 2'b00;
    chk("flush1_l1", level[LW+:LW], 5'd0);
    drive(1'b1, OP_AES, 24'h600);
    tick;
    drive(1'b0, OP_AES, 24'h0);
    chk("post_flush_l0", level[0+:LW], 5'd1);
    chk("post_flush_head0", instr_out[0+:IW], exp_req(OP_AES, 24'h600));
    v3 = 1'b1;
    op3 = 2'b00;
    tick;
    op3 = 2'b10;
    tick;
    v3 = 1'b0;
    chk("err_pre_lvl3", lvl3, {5'd1, 5'd0, 5'd1});
    chk("err_pre_low", e3, 1'b0);
    v3 = 1'b1;
    op3 = 2'b11;
    #1;
    chk("err_ready_in", r3, 1'b1);
    tick;
    v3 = 1'b0;
    chk("err_pulse", e3, 1'b1);
    chk("err_lvl3", lvl3, {5'd1, 5'd0, 5'd1});
    tick;
    chk("err_pulse_end", e3, 1'b0);
    chk("err_default_dut", err_route, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
